circle_plotter: RTL and testbench



---
 rtl/circle_plotter.sv | 257 +++++++++++++++++++++++++
 tb/tb_circle_plotter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/circle_plotter.sv
// Midpoint-circle rasteriser: one pixel per cycle over eight octants with off-screen clipping.
// Define CIRCLE_PLOTTER_CLEAR_EN to raster-clear the framebuffer to colour 0 before every draw.
module circle_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [X_W-1:0]      radius,
    input  logic [COLOUR_W-1:0] colour,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int PW = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int CW = X_W + 3;
    localparam logic [X_W-1:0]        ONE_X  = {{(X_W-1){1'b0}}, 1'b1};
    localparam logic signed [CW-1:0]  ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0]  ZERO_P = {PW{1'b0}};
    localparam logic signed [PW-1:0]  SW_P   = PW'(SCREEN_W);
    localparam logic signed [PW-1:0]  SH_P   = PW'(SCREEN_H);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        INIT  = 3'd2,
        PLOT  = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [X_W-1:0]        cx_r, rad_r, ox_r, ox_s, oy_r, oy_s;
    logic [Y_W-1:0]        cy_r;
    logic [COLOUR_W-1:0]   col_r;
    logic [2:0]            oct_r, oct_s;
    logic signed [CW-1:0]  crit_r, crit_s;

    logic [X_W-1:0]        oy_inc_s, ox_step_s;
    logic [X_W:0]          ox_dec_w_s;
    logic signed [CW-1:0]  oy_c_s, ox_c_s, rad_c_s, crit_step_s;
    logic                  more_s;

`ifdef CIRCLE_PLOTTER_CLEAR_EN
    logic [X_W-1:0]        clr_x_r, clr_x_s;
    logic [Y_W-1:0]        clr_y_r, clr_y_s;
`endif

    logic signed [PW-1:0]  cxp_s, cyp_s, oxp_s, oyp_s, px_s, py_s;
    logic                  in_bounds_s;
    logic                  done_s, plot_s;
    logic [X_W-1:0]        x_s;
    logic [Y_W-1:0]        y_s;
    logic [COLOUR_W-1:0]   colour_s;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath logic; STEP detects ox underflowing below zero
    always_comb begin
        state_s     = state_r;
        ox_s        = ox_r;
        oy_s        = oy_r;
        crit_s      = crit_r;
        oct_s       = oct_r;
`ifdef CIRCLE_PLOTTER_CLEAR_EN
        clr_x_s     = clr_x_r;
        clr_y_s     = clr_y_r;
`endif
        oy_inc_s    = oy_r + ONE_X;
        ox_dec_w_s  = {1'b0, ox_r} - {{X_W{1'b0}}, 1'b1};
        oy_c_s      = $signed({{(CW-X_W){1'b0}}, oy_inc_s});
        ox_c_s      = $signed({{(CW-X_W){1'b0}}, ox_dec_w_s[X_W-1:0]});
        rad_c_s     = $signed({{(CW-X_W){1'b0}}, rad_r});
        if (crit_r[CW-1] || (crit_r == {CW{1'b0}})) begin
            ox_step_s   = ox_r;
            crit_step_s = crit_r + (oy_c_s <<< 1) + ONE_C;
            more_s      = (oy_inc_s <= ox_r);
        end else begin
            ox_step_s   = ox_dec_w_s[X_W-1:0];
            crit_step_s = crit_r + ((oy_c_s - ox_c_s) <<< 1) + ONE_C;
            more_s      = !ox_dec_w_s[X_W] && (oy_inc_s <= ox_dec_w_s[X_W-1:0]);
        end
        case (state_r)
            IDLE: begin
                if (start) begin
`ifdef CIRCLE_PLOTTER_CLEAR_EN
                    state_s = CLEAR;
                    clr_x_s = {X_W{1'b0}};
                    clr_y_s = {Y_W{1'b0}};
`else
                    state_s = INIT;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef CIRCLE_PLOTTER_CLEAR_EN
            CLEAR: begin
                if (clr_x_r == X_W'(SCREEN_W - 1)) begin
                    clr_x_s = {X_W{1'b0}};
                    if (clr_y_r == Y_W'(SCREEN_H - 1)) begin
                        state_s = INIT;
                    end else begin
                        clr_y_s = clr_y_r + {{(Y_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    clr_x_s = clr_x_r + ONE_X;
                end
            end
`endif
            INIT: begin
                ox_s    = rad_r;
                oy_s    = {X_W{1'b0}};
                crit_s  = ONE_C - rad_c_s;
                oct_s   = 3'd0;
                state_s = PLOT;
            end
            PLOT: begin
                if (oct_r == 3'd7) begin
                    state_s = STEP;
                end else begin
                    oct_s = oct_r + 3'd1;
                end
            end
            STEP: begin
                oy_s    = oy_inc_s;
                ox_s    = ox_step_s;
                crit_s  = crit_step_s;
                oct_s   = 3'd0;
                state_s = more_s ? PLOT : DONE;
            end
            DONE: begin
                if (!start) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output logic: the pixel for the coming state cycle, so it is visible during that cycle
    always_comb begin
        cxp_s = $signed({{(PW-X_W){1'b0}}, cx_r});
        cyp_s = $signed({{(PW-Y_W){1'b0}}, cy_r});
        oxp_s = $signed({{(PW-X_W){1'b0}}, ox_s});
        oyp_s = $signed({{(PW-X_W){1'b0}}, oy_s});
        case (oct_s)
            3'd0:    begin px_s = cxp_s + oxp_s; py_s = cyp_s + oyp_s; end
            3'd1:    begin px_s = cxp_s + oyp_s; py_s = cyp_s + oxp_s; end
            3'd2:    begin px_s = cxp_s - oxp_s; py_s = cyp_s + oyp_s; end
            3'd3:    begin px_s = cxp_s - oyp_s; py_s = cyp_s + oxp_s; end
            3'd4:    begin px_s = cxp_s - oxp_s; py_s = cyp_s - oyp_s; end
            3'd5:    begin px_s = cxp_s - oyp_s; py_s = cyp_s - oxp_s; end
            3'd6:    begin px_s = cxp_s + oxp_s; py_s = cyp_s - oyp_s; end
            3'd7:    begin px_s = cxp_s + oyp_s; py_s = cyp_s - oxp_s; end
            default: begin px_s = cxp_s;         py_s = cyp_s;         end
        endcase
        in_bounds_s = (px_s >= ZERO_P) && (px_s < SW_P) && (py_s >= ZERO_P) && (py_s < SH_P);
        done_s   = 1'b0;
        plot_s   = 1'b0;
        x_s      = {X_W{1'b0}};
        y_s      = {Y_W{1'b0}};
        colour_s = {COLOUR_W{1'b0}};
        case (state_s)
`ifdef CIRCLE_PLOTTER_CLEAR_EN
            CLEAR: begin
                plot_s = 1'b1;
                x_s    = clr_x_s;
                y_s    = clr_y_s;
            end
`endif
            PLOT: begin
                plot_s   = in_bounds_s;
                x_s      = px_s[X_W-1:0];
                y_s      = py_s[Y_W-1:0];
                colour_s = col_r;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath registers; request operands are captured only when leaving IDLE
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            cx_r    <= {X_W{1'b0}};
            cy_r    <= {Y_W{1'b0}};
            rad_r   <= {X_W{1'b0}};
            col_r   <= {COLOUR_W{1'b0}};
            ox_r    <= {X_W{1'b0}};
            oy_r    <= {X_W{1'b0}};
            crit_r  <= {CW{1'b0}};
            oct_r   <= 3'd0;
`ifdef CIRCLE_PLOTTER_CLEAR_EN
            clr_x_r <= {X_W{1'b0}};
            clr_y_r <= {Y_W{1'b0}};
`endif
        end else begin
            if ((state_r == IDLE) && start) begin
                cx_r  <= centre_x;
                cy_r  <= centre_y;
                rad_r <= radius;
                col_r <= colour;
            end
            ox_r    <= ox_s;
            oy_r    <= oy_s;
            crit_r  <= crit_s;
            oct_r   <= oct_s;
`ifdef CIRCLE_PLOTTER_CLEAR_EN
            clr_x_r <= clr_x_s;
            clr_y_r <= clr_y_s;
`endif
        end
    end

    // Registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= {X_W{1'b0}};
            vga_y      <= {Y_W{1'b0}};
            vga_colour <= {COLOUR_W{1'b0}};
        end else begin
            done       <= done_s;
            vga_plot   <= plot_s;
            vga_x      <= x_s;
            vga_y      <= y_s;
            vga_colour <= colour_s;
        end
    end

endmodule

// File: tb/tb_circle_plotter.sv
// Directed self-checking bench for circle_plotter: reset, radius 0/1, clipping, ignored restarts.
module tb_circle_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

`ifdef CIRCLE_PLOTTER_CLEAR_EN
    localparam int CLR = 19200;
`else
    localparam int CLR = 0;
`endif

    int errors = 0;
    int checks = 0;
    int px[$];
    int py[$];
    int pc[$];
    int first_tick;
    int done_tick;
    int clr_bad;
    int clr_n;

    int ex1[16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
    int ey1[16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};

    circle_plotter dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .centre_x  (centre_x),
        .centre_y  (centre_y),
        .radius    (radius),
        .colour    (colour),
        .done      (done),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Raise start and record every plotted pixel until done, within a cycle budget
    task automatic draw(input int cx, input int cy, input int r, input int col,
                        input int budget, input bit toggle);
        px.delete();
        py.delete();
        pc.delete();
        first_tick = -1;
        done_tick  = -1;
        clr_bad    = 0;
        clr_n      = 0;
        centre_x = cx[7:0];
        centre_y = cy[6:0];
        radius   = r[7:0];
        colour   = col[2:0];
        start    = 1'b1;
        for (int t = 1; t <= budget + CLR; t++) begin
            tick();
            if (vga_plot) begin
                if (first_tick < 0) first_tick = t;
                if (clr_n < CLR) begin
                    if (vga_x != 8'((clr_n % 160)) || vga_y != 7'((clr_n / 160)) || vga_colour != 3'd0)
                        clr_bad++;
                    clr_n++;
                end else begin
                    px.push_back(int'(vga_x));
                    py.push_back(int'(vga_y));
                    pc.push_back(int'(vga_colour));
                end
            end
            if (done) begin
                done_tick = t;
                break;
            end
            if (toggle && t == CLR + 4) begin
                start    = 1'b0;
                centre_x = 8'd20;
            end
            if (toggle && t == CLR + 5) start = 1'b1;
        end
`ifdef CIRCLE_PLOTTER_CLEAR_EN
        check("clear_scan_bad", clr_bad, 0);
        check("clear_count", clr_n, CLR);
`endif
    endtask

    task automatic release_start();
        start = 1'b0;
        tick();
    endtask

    task automatic check_radius1(input string tag);
        check({tag, "_count"}, px.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < px.size()) begin
                check($sformatf("%s_x%0d", tag, i), px[i], ex1[i]);
                check($sformatf("%s_y%0d", tag, i), py[i], ey1[i]);
                check($sformatf("%s_c%0d", tag, i), pc[i], 5);
            end
        end
        check({tag, "_done_tick"}, done_tick, 20 + CLR);
    endtask

    initial begin
        int nplot;
        int d;
        resetn   = 1'b0;
        start    = 1'b0;
        centre_x = 8'd0;
        centre_y = 7'd0;
        radius   = 8'd0;
        colour   = 3'd0;
        tick();
        tick();
        check("rst_done", done, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        resetn = 1'b1;
        tick();
        check("idle_plot", vga_plot, 0);

        // radius 0: eight pixels at the centre
        draw(80, 60, 0, 2, 30, 1'b0);
        check("r0_count", px.size(), 8);
        for (int i = 0; i < px.size(); i++) begin
            check($sformatf("r0_x%0d", i), px[i], 80);
            check($sformatf("r0_y%0d", i), py[i], 60);
            check($sformatf("r0_c%0d", i), pc[i], 2);
        end
        check("r0_first_tick", first_tick, (CLR > 0) ? 1 : 2);
        check("r0_done_tick", done_tick, 11 + CLR);
        tick();
        tick();
        check("r0_done_held", done, 1);
        check("r0_no_plot_done", vga_plot, 0);
        release_start();
        check("r0_done_cleared", done, 0);

        // radius 1: two iterations in fixed octant order
        draw(80, 60, 1, 5, 40, 1'b0);
        check_radius1("r1");
        release_start();

        // clipping around the origin
        draw(0, 0, 10, 7, 100, 1'b0);
        check("clip_count", px.size(), 18);
        if (px.size() > 0) begin
            check("clip_first_x", px[0], 10);
            check("clip_first_y", py[0], 0);
        end
        for (int i = 0; i < px.size(); i++) begin
            d = px[i] * px[i] + py[i] * py[i] - 100;
            if (d < 0) d = -d;
            check($sformatf("clip_dist%0d", i), int'(d <= 10), 1);
        end
        check("clip_done_tick", done_tick, 74 + CLR);
        release_start();

        // start toggled mid-draw with a new centre_x: must be ignored
        draw(80, 60, 1, 5, 40, 1'b1);
        check_radius1("tog");
        release_start();

        // reset asserted mid-draw
        centre_x = 8'd80;
        centre_y = 7'd60;
        radius   = 8'd10;
        colour   = 3'd7;
        start    = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        resetn = 1'b0;
        tick();
        tick();
        check("mid_rst_done", done, 0);
        check("mid_rst_plot", vga_plot, 0);
        check("mid_rst_x", vga_x, 0);
        check("mid_rst_y", vga_y, 0);
        check("mid_rst_colour", vga_colour, 0);
        start  = 1'b0;
        resetn = 1'b1;
        nplot  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (vga_plot || done) nplot++;
        end
        check("post_rst_quiet", nplot, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
